// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: id_* and the stall/flush controls flow into the stage.
// ex_*, the hazard outputs and the bubble counter flow back out.
interface id_ex_stage_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
);
    logic             stall_i;
    logic             flush_i;

    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_rs1_data;
    logic [XLEN-1:0]  id_rs2_data;
    logic [XLEN-1:0]  id_imm;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic [3:0]       id_funct;
    logic             id_alusrc;
    logic             id_memtoreg;
    logic             id_regwrite;
    logic             id_memread;
    logic             id_memwrite;
    logic             id_branch;
    logic [2:0]       id_aluop;

    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_rs1_data;
    logic [XLEN-1:0]  ex_rs2_data;
    logic [XLEN-1:0]  ex_imm;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic [3:0]       ex_funct;
    logic             ex_alusrc;
    logic             ex_memtoreg;
    logic             ex_regwrite;
    logic             ex_memread;
    logic             ex_memwrite;
    logic             ex_branch;
    logic [2:0]       ex_aluop;

    logic             hazard;
    logic             pc_write;
    logic             ifid_write;
    logic [CNT_W-1:0] bubble_count;

    modport master (
        output stall_i, flush_i,
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
        output id_rs1, id_rs2, id_rd, id_funct,
        output id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_aluop,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        input  ex_rs1, ex_rs2, ex_rd, ex_funct,
        input  ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_aluop,
        input  hazard, pc_write, ifid_write, bubble_count
    );

    modport slave (
        input  stall_i, flush_i,
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
        input  id_rs1, id_rs2, id_rd, id_funct,
        input  id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_aluop,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        output ex_rs1, ex_rs2, ex_rd, ex_funct,
        output ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_aluop,
        output hazard, pc_write, ifid_write, bubble_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV64 core with the load-use hazard detector
// and a saturating counter of inserted load-use bubbles.
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      funct;
        logic            alusrc;
        logic            memtoreg;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            branch;
        logic [2:0]      aluop;
    } ex_slot_t;

    ex_slot_t         ex_q, ex_d, id_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard_w;
    logic             rd_match_w;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // rs2 is compared for every opcode; a false stall on I-type/loads is harmless.
    assign rd_match_w = (ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2);
    assign hazard_w   = !rst && ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0)
                        && bus.id_valid && rd_match_w;

    assign bus.hazard     = hazard_w;
    assign bus.pc_write   = !(hazard_w || bus.stall_i);
    assign bus.ifid_write = !(hazard_w || bus.stall_i);

    always_comb begin
        id_s          = '0;
        id_s.valid    = bus.id_valid;
        id_s.pc       = bus.id_pc;
        id_s.rs1_data = bus.id_rs1_data;
        id_s.rs2_data = bus.id_rs2_data;
        id_s.imm      = bus.id_imm;
        id_s.rs1      = bus.id_rs1;
        id_s.rs2      = bus.id_rs2;
        id_s.rd       = bus.id_rd;
        id_s.funct    = bus.id_funct;
        // An empty decode slot must never leak control bits into EX.
        if (bus.id_valid) begin
            id_s.alusrc   = bus.id_alusrc;
            id_s.memtoreg = bus.id_memtoreg;
            id_s.regwrite = bus.id_regwrite;
            id_s.memread  = bus.id_memread;
            id_s.memwrite = bus.id_memwrite;
            id_s.branch   = bus.id_branch;
            id_s.aluop    = bus.id_aluop;
        end
    end

    // Priority below reset: stall holds everything, then flush, then load-use bubble.
    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (!bus.stall_i) begin
            if (bus.flush_i) begin
                ex_d = '0;
            end else if (hazard_w) begin
                ex_d  = '0;
                cnt_d = sat_inc(cnt_q);
            end else begin
                ex_d = id_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_pc        = ex_q.pc;
    assign bus.ex_rs1_data  = ex_q.rs1_data;
    assign bus.ex_rs2_data  = ex_q.rs2_data;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_rs1       = ex_q.rs1;
    assign bus.ex_rs2       = ex_q.rs2;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.ex_funct     = ex_q.funct;
    assign bus.ex_alusrc    = ex_q.alusrc;
    assign bus.ex_memtoreg  = ex_q.memtoreg;
    assign bus.ex_regwrite  = ex_q.regwrite;
    assign bus.ex_memread   = ex_q.memread;
    assign bus.ex_memwrite  = ex_q.memwrite;
    assign bus.ex_branch    = ex_q.branch;
    assign bus.ex_aluop     = ex_q.aluop;
    assign bus.bubble_count = cnt_q;

endmodule
